// File: rtl/lights_pkg.sv
// Shared definitions for the lighting pipeline: colour word layout,
// named colours and the PWM resolution.
package lights_pkg;

    localparam int PWM_W  = 8;
    localparam int NUM_CH = 3;

    localparam int R_MSB = 23;
    localparam int R_LSB = 16;
    localparam int G_MSB = 15;
    localparam int G_LSB = 8;
    localparam int B_MSB = 7;
    localparam int B_LSB = 0;

    localparam logic [23:0] C_WHITE = 24'hFFFFFF;
    localparam logic [23:0] C_OFF   = 24'h000000;

    typedef enum logic [1:0] {
        CH_R = 2'd0,
        CH_G = 2'd1,
        CH_B = 2'd2
    } channel_e;

    function automatic logic [PWM_W-1:0] colour_field(input logic [23:0] colour,
                                                      input channel_e    ch);
        case (ch)
            CH_R:    return colour[R_MSB:R_LSB];
            CH_G:    return colour[G_MSB:G_LSB];
            default: return colour[B_MSB:B_LSB];
        endcase
    endfunction

endpackage

// File: rtl/pwm_channel.sv
// One PWM channel: holds the sampled target and the active duty, steps or
// jumps the duty at each period boundary and produces a registered pin.
module pwm_channel
    import lights_pkg::*;
#(
    parameter bit FADE_EN = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             boundary,
    input  logic [PWM_W-1:0] pwm_cnt,
    input  logic [PWM_W-1:0] target,
    input  logic             enable,
    output logic             led,
    output logic             neq
);

    logic [PWM_W-1:0] duty_q, duty_d;
    logic [PWM_W-1:0] target_q, target_d;
    logic             led_q, led_d;

    always_comb begin
        duty_d   = duty_q;
        target_d = target_q;
        if (boundary) begin
            target_d = target;
            // Fade compares against the freshly sampled colour, not the held
            // target, so a redirect takes effect on the very same boundary.
            if (!FADE_EN) begin
                duty_d = target;
            end else if (duty_q < target) begin
                duty_d = duty_q + 1'b1;
            end else if (duty_q > target) begin
                duty_d = duty_q - 1'b1;
            end
        end
        led_d = enable && (pwm_cnt < duty_q);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            duty_q   <= '0;
            target_q <= '0;
            led_q    <= 1'b0;
        end else begin
            duty_q   <= duty_d;
            target_q <= target_d;
            led_q    <= led_d;
        end
    end

    assign led = led_q;
    assign neq = (duty_q != target_q);

endmodule

// File: rtl/rgb_pwm_driver.sv
// Three-channel 8-bit LED PWM driver; the colour is sampled only at period
// boundaries so pins never glitch mid-period.
module rgb_pwm_driver
    import lights_pkg::*;
#(
    parameter int unsigned PRESCALE = 4,
    parameter bit          FADE_EN  = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [23:0] light,
    input  logic        enable,
    output logic        led_r,
    output logic        led_g,
    output logic        led_b,
    output logic        frame,
    output logic        busy
);

    localparam int          PRE_W    = 16;
    localparam logic [15:0] PRE_LAST = 16'(PRESCALE - 1);

    logic [PRE_W-1:0]  pre_cnt_q, pre_cnt_d;
    logic [PWM_W-1:0]  pwm_cnt_q, pwm_cnt_d;
    logic              frame_q, frame_d;
    logic              tick;
    logic              boundary;
    logic [NUM_CH-1:0] led_vec;
    logic [NUM_CH-1:0] neq_vec;

    assign tick     = (pre_cnt_q == PRE_LAST);
    assign boundary = tick && (pwm_cnt_q == {PWM_W{1'b1}});

    always_comb begin
        pre_cnt_d = tick ? '0 : pre_cnt_q + 1'b1;
        pwm_cnt_d = tick ? pwm_cnt_q + 1'b1 : pwm_cnt_q;
        frame_d   = boundary;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pre_cnt_q <= '0;
            pwm_cnt_q <= '0;
            frame_q   <= 1'b0;
        end else begin
            pre_cnt_q <= pre_cnt_d;
            pwm_cnt_q <= pwm_cnt_d;
            frame_q   <= frame_d;
        end
    end

    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
        pwm_channel #(
            .FADE_EN (FADE_EN)
        ) u_ch (
            .clk      (clk),
            .rst      (rst),
            .boundary (boundary),
            .pwm_cnt  (pwm_cnt_q),
            .target   (colour_field(light, channel_e'(gi))),
            .enable   (enable),
            .led      (led_vec[gi]),
            .neq      (neq_vec[gi])
        );
    end

    assign led_r = led_vec[CH_R];
    assign led_g = led_vec[CH_G];
    assign led_b = led_vec[CH_B];
    assign frame = frame_q;
    assign busy  = FADE_EN ? (|neq_vec) : 1'b0;

endmodule

// File: tb/tb_rgb_pwm_driver.sv
// Randomized bench: a fading and a jumping driver share the same stimulus and
// are compared every cycle against a period/position arithmetic model.
module tb_rgb_pwm_driver;
    import lights_pkg::*;

    localparam int P      = 3;
    localparam int PERIOD = 256 * P;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [23:0] light = 24'h0;
    logic        enable = 1'b1;

    logic led_r_f, led_g_f, led_b_f, frame_f, busy_f;
    logic led_r_j, led_g_j, led_b_j, frame_j, busy_j;

    always #5 clk = ~clk;

    rgb_pwm_driver #(.PRESCALE(P), .FADE_EN(1'b1)) dut_f (
        .clk(clk), .rst(rst), .light(light), .enable(enable),
        .led_r(led_r_f), .led_g(led_g_f), .led_b(led_b_f),
        .frame(frame_f), .busy(busy_f)
    );

    rgb_pwm_driver #(.PRESCALE(P), .FADE_EN(1'b0)) dut_j (
        .clk(clk), .rst(rst), .light(light), .enable(enable),
        .led_r(led_r_j), .led_g(led_g_j), .led_b(led_b_j),
        .frame(frame_j), .busy(busy_j)
    );

    int total = 0;
    int bad   = 0;

    // model: index 0 = fading driver, 1 = jumping driver; channel 0=R,1=G,2=B
    int m_cyc;
    int m_duty[2][3];
    int m_target[2][3];
    bit m_led[2][3];
    bit m_frame;
    bit rand_on;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s cyc=%0d: got %0h expected %0h", tag, m_cyc, obs, exp);
        end
    endtask

    function automatic int field(input logic [23:0] c, input int ch);
        int v;
        v = int'(c);
        return (v >> (16 - 8 * ch)) & 255;
    endfunction

    task automatic model_reset();
        m_cyc   = 0;
        m_frame = 1'b0;
        for (int m = 0; m < 2; m++) begin
            for (int c = 0; c < 3; c++) begin
                m_duty[m][c]   = 0;
                m_target[m][c] = 0;
                m_led[m][c]    = 1'b0;
            end
        end
    endtask

    // Advance the model over one clock edge using the inputs now applied.
    task automatic model_step();
        int pos, cnt, f;
        bit bnd;
        pos = m_cyc % PERIOD;
        cnt = pos / P;
        bnd = (pos == PERIOD - 1);
        for (int m = 0; m < 2; m++)
            for (int c = 0; c < 3; c++)
                m_led[m][c] = enable && (cnt < m_duty[m][c]);
        m_frame = bnd;
        if (bnd) begin
            for (int c = 0; c < 3; c++) begin
                f = field(light, c);
                m_target[0][c] = f;
                m_target[1][c] = f;
                m_duty[1][c]   = f;
                if (f > m_duty[0][c])      m_duty[0][c] = m_duty[0][c] + 1;
                else if (f < m_duty[0][c]) m_duty[0][c] = m_duty[0][c] - 1;
            end
        end
        m_cyc++;
    endtask

    task automatic check_all();
        bit exp_busy;
        exp_busy = 1'b0;
        for (int c = 0; c < 3; c++)
            if (m_duty[0][c] != m_target[0][c]) exp_busy = 1'b1;
        chk("led_r_fade", 32'(led_r_f), 32'(m_led[0][0]));
        chk("led_g_fade", 32'(led_g_f), 32'(m_led[0][1]));
        chk("led_b_fade", 32'(led_b_f), 32'(m_led[0][2]));
        chk("frame_fade", 32'(frame_f), 32'(m_frame));
        chk("busy_fade",  32'(busy_f),  32'(exp_busy));
        chk("led_r_jump", 32'(led_r_j), 32'(m_led[1][0]));
        chk("led_g_jump", 32'(led_g_j), 32'(m_led[1][1]));
        chk("led_b_jump", 32'(led_b_j), 32'(m_led[1][2]));
        chk("frame_jump", 32'(frame_j), 32'(m_frame));
        chk("busy_jump",  32'(busy_j),  32'(0));
    endtask

    function automatic logic [23:0] pick_light();
        logic [23:0] v;
        case ($urandom_range(0, 3))
            0:       v = 24'($urandom);
            1:       v = C_WHITE;
            2:       v = C_OFF;
            default: v = {8'($urandom_range(0, 6)), 8'($urandom_range(0, 6)),
                          8'($urandom_range(0, 6))};
        endcase
        return v;
    endfunction

    // Called at a negedge: apply inputs, advance model, check at next negedge.
    task automatic run(input int n);
        for (int i = 0; i < n; i++) begin
            if (rand_on) begin
                if ($urandom_range(0, 399) == 0) light = pick_light();
                if ((m_cyc % PERIOD) == PERIOD - 1 && $urandom_range(0, 2) == 0)
                    light = pick_light();
                if ($urandom_range(0, 599) == 0) enable = ~enable;
            end
            model_step();
            @(negedge clk);
            check_all();
        end
    endtask

    initial begin
        rand_on = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        check_all();

        rst     = 1'b0;
        light   = 24'hFF0000;
        rand_on = 1'b1;
        run(24 * PERIOD);

        // Drive full white with no randomness so pins are high when reset hits.
        rand_on = 1'b0;
        light   = C_WHITE;
        enable  = 1'b1;
        run(2 * PERIOD + (PERIOD - (m_cyc % PERIOD)) + 100 * P);

        #2 rst = 1'b1;
        #1;
        chk("async_rst_led_r", 32'(led_r_j), 32'(0));
        chk("async_rst_led_g", 32'(led_g_j), 32'(0));
        chk("async_rst_led_b", 32'(led_b_j), 32'(0));
        chk("async_rst_led_r_fade", 32'(led_r_f), 32'(0));
        chk("async_rst_busy_fade", 32'(busy_f), 32'(0));
        model_reset();
        repeat (2) @(negedge clk);
        check_all();
        rst = 1'b0;

        // First period after release must be dark even with white requested.
        run(PERIOD + 50);
        rand_on = 1'b1;
        run(16 * PERIOD);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/rgb_pwm_driver.md
Name: rgb_pwm_driver

Overview:
Downstream stage of light_selector. Consumes its 24-bit RGB colour word (R=[23:16], G=[15:8], B=[7:0]) and drives three physical LED pins with 8-bit PWM. The colour is sampled only at PWM period boundaries, so outputs never glitch mid-period. An optional linear fade ramps each channel toward the new colour by one step per period.

Parameters:
PRESCALE, 4, clk cycles per PWM count tick; legal range 1..65535; period = 256*PRESCALE cycles
FADE_EN, 1, 1 = duty steps ±1 per period toward target; 0 = duty jumps to target at boundary

Ports:
clk  input  1  system clock
rst  input  1  asynchronous, active-high reset
light  input  24  colour from light_selector: R=[23:16], G=[15:8], B=[7:0]
enable  input  1  1 = drive LEDs; 0 = force LED pins low (counters keep running)
led_r  output  1  red PWM pin, registered
led_g  output  1  green PWM pin, registered
led_b  output  1  blue PWM pin, registered
frame  output  1  one-cycle pulse, first cycle of each PWM period
busy  output  1  high while any channel duty != target (always 0 when FADE_EN=0)

Behaviour:
- Reset (async assert, sync release): pre_cnt=0, pwm_cnt=0, duty_r/g/b=0, target_r/g/b=0; led_r/g/b=0, frame=0, busy=0.
- Prescaler: pre_cnt counts 0..PRESCALE-1 and wraps. tick = (pre_cnt==PRESCALE-1). With PRESCALE=1, tick is high every cycle.
- PWM counter: 8-bit pwm_cnt increments on tick and wraps 255->0.
- Boundary: the cycle where tick && pwm_cnt==255.
- At the boundary, target_x <= light field, sampled in that cycle only. Changes to light at any other time are ignored.
- Duty update at the boundary:
  - FADE_EN=0: duty_x <= light field.
  - FADE_EN=1: duty_x <= duty_x+1 if duty_x < light field, duty_x-1 if greater, unchanged if equal. Compare against the freshly sampled value.
  - New duty takes effect from pwm_cnt=0 of the next period.
- frame: registered; high for exactly one clk cycle, the cycle after the boundary (pwm_cnt==0, pre_cnt==0).
- Output: led_x <= enable && (pwm_cnt < duty_x), registered, so one-cycle latency from pwm_cnt.
  - duty 0 gives a pin that is always low.
  - duty 255 gives 255/256 high. Full-on is deliberately not reachable; this is required.
- enable=0: led pins are 0 on the next clk edge. pre_cnt, pwm_cnt, duty, target and fade keep running. Re-enable resumes output on the next edge, mid-period allowed.
- busy: (duty_r!=target_r)||(duty_g!=target_g)||(duty_b!=target_b), from registers. Forced 0 when FADE_EN=0.
- Fade length: a channel step of N takes N periods. A target change mid-fade redirects from the current duty value; the fade does not restart.
- Reset mid-period: all state returns to reset values immediately (async). The first period after release has duty 0, so all LEDs are off.
- No arithmetic overflow: duty only steps toward a target inside 0..255.

Decomposition:
- Shared package lights_pkg holds:
  - PWM_W=8
  - colour field slices R_MSB/R_LSB, G_MSB/G_LSB, B_MSB/B_LSB
  - colour constants C_WHITE=24'hFFFFFF and C_OFF=24'h000000, shared with light_selector
- Sub-module pwm_channel, instantiated 3 times.
  - Inputs: clk, rst, boundary, pwm_cnt, target, enable.
  - Outputs: led, neq.
  - Contains duty/target registers, fade step and compare.
- The top level holds the prescaler, pwm_cnt, frame and the busy OR.

Test Plan:
- Reset / static colour: PRESCALE=1, FADE_EN=0, light=24'hFF0000, enable=1 from reset. Period 0 all pins 0. From period 1 on: led_r high 255 of every 256 cycles, led_g=led_b=0. frame pulses every 256 cycles.
- Mid-period change ignored: FADE_EN=0, light=24'h000080 steady, then switched to 24'h000010 at pwm_cnt=100. led_b stays 128/256 for the current period and becomes 16/256 from the next period.
- Fade up: FADE_EN=1, duty 0, light=24'h030000. busy=1 after the first boundary. duty_r goes 1,2,3 over three periods (led_r high 1,2,3 cycles per period). busy falls when duty_r=3.
- Fade redirect: FADE_EN=1, fading 0->0x10, at duty 5 change light to 24'h000000. duty_r counts down 4..0. busy deasserts after 5 further boundaries.
- Enable gating: duty_g=0x40, enable dropped at pwm_cnt=10. led_g=0 from the next edge. frame keeps pulsing every period. Re-enable at pwm_cnt=20 gives led_g high for pwm_cnt 20..63.
- Prescale / async reset: PRESCALE=4 gives frame spacing of 1024 cycles. Asserting rst mid-period zeroes all outputs before the next clk edge; after release the first period is dark.
